// File: rtl/sram_ifc_pkg.sv
// Shared definitions for the fabric-to-SRAM interface: access-width encoding
// and the lane arithmetic used on both the write and read sides.
package sram_ifc_pkg;

    typedef enum logic [2:0] {
        W1  = 3'd0,
        W2  = 3'd1,
        W4  = 3'd2,
        W8  = 3'd3,
        W16 = 3'd4,
        W32 = 3'd5,
        W64 = 3'd6
    } conf_e;

    localparam int MAX_W = 64;

    // Lane exponent clamps to the row width, so oversized widths mean full-row access.
    function automatic int eff_exp(input int conf, input int sub_w);
        return (conf < sub_w) ? conf : sub_w;
    endfunction

    function automatic int align_off(input int sub, input int c);
        return sub & ~((1 << c) - 1);
    endfunction

    function automatic logic [MAX_W-1:0] lane_mask(input int c, input int o);
        logic [MAX_W-1:0] low;
        low = {MAX_W{1'b1}} >> (MAX_W - (1 << c));
        return low << o;
    endfunction

endpackage

// File: rtl/sram_ifc_param_shifter.sv
// Combinational lane helper: replicates a lane across a row, builds its bit
// mask, and extracts a lane from a row.
module sram_lane_shifter
    import sram_ifc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SUB_W  = $clog2(DATA_W),
    parameter int EXP_W  = $clog2(SUB_W + 1)
) (
    input  logic [EXP_W-1:0]  c_i,
    input  logic [SUB_W-1:0]  o_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] repl_o,
    output logic [DATA_W-1:0] mask_o,
    output logic [DATA_W-1:0] ext_o
);

    logic [SUB_W-1:0] low_idx;

    assign low_idx = SUB_W'((1 << c_i) - 1);

    // Each row bit takes the lane bit at the same position modulo the lane width.
    always_comb begin
        repl_o = '0;
        for (int b = 0; b < DATA_W; b++) begin
            repl_o[b] = data_i[SUB_W'(b) & low_idx];
        end
    end

    assign mask_o = DATA_W'(lane_mask(int'(c_i), int'(o_i)));
    assign ext_o  = (data_i >> o_i) & DATA_W'(lane_mask(int'(c_i), 0));

endmodule

// File: rtl/sram_ifc_param.sv
// Fabric-to-SRAM interface for a 1W/1R macro: masked sub-word writes, lane
// extraction on reads, same-row collision forwarding and a collision counter.
module sram_ifc_param
    import sram_ifc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BASE_W = 9,
    parameter int SUB_W  = $clog2(DATA_W),
    parameter int ADDR_W = BASE_W + SUB_W,
    parameter int CONF_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_fabric_in,
    input  logic              csb,
    input  logic              web,
    input  logic              reb,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [ADDR_W-1:0] addr_r,
    input  logic [CONF_W-1:0] conf,
    input  logic              out_reg,
    output logic [DATA_W-1:0] d_sram_in,
    output logic [DATA_W-1:0] w_mask,
    output logic              csb0_sync,
    output logic              web0_sync,
    output logic              csb1_sync,
    output logic [BASE_W-1:0] baseaddr_w_sync,
    output logic [BASE_W-1:0] baseaddr_r_sync,
    input  logic [DATA_W-1:0] d_sram_out,
    output logic [DATA_W-1:0] d_fabric_out,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  collision_cnt
);

    localparam int EXP_W = $clog2(SUB_W + 1);

    typedef struct packed {
        logic              valid;
        logic              fwd;
        logic              oreg;
        logic [EXP_W-1:0]  c;
        logic [SUB_W-1:0]  o;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] wmask;
    } pipe_t;

    logic              wr_req, rd_req, collide_req;
    logic [EXP_W-1:0]  c_req;
    logic [SUB_W-1:0]  o_w_req, o_r_req;
    logic [DATA_W-1:0] wr_repl, wr_mask, wr_ext_unused;
    logic [DATA_W-1:0] rd_repl_unused, rd_mask_unused, rd_lane, row_fwd;

    pipe_t             s1_d, s1_q, s2_q, s3_q;
    logic              csb0_q, web0_q, csb1_q, v4_q;
    logic [BASE_W-1:0] base_w_q, base_r_q;
    logic [DATA_W-1:0] row3_q, lane4_d, lane4_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              direct;

    assign wr_req      = ~csb & ~web;
    assign rd_req      = ~csb & ~reb;
    assign collide_req = wr_req & rd_req & (addr_w[ADDR_W-1:SUB_W] == addr_r[ADDR_W-1:SUB_W]);
    assign c_req       = EXP_W'(eff_exp(int'(conf), SUB_W));
    assign o_w_req     = SUB_W'(align_off(int'(addr_w[SUB_W-1:0]), int'(c_req)));
    assign o_r_req     = SUB_W'(align_off(int'(addr_r[SUB_W-1:0]), int'(c_req)));

    sram_lane_shifter #(.DATA_W(DATA_W), .SUB_W(SUB_W), .EXP_W(EXP_W)) u_wr_shift (
        .c_i    (c_req),
        .o_i    (o_w_req),
        .data_i (d_fabric_in),
        .repl_o (wr_repl),
        .mask_o (wr_mask),
        .ext_o  (wr_ext_unused)
    );

    // The SRAM read of a colliding row is unreliable under the write mask, so
    // the written lane is patched in from the write values carried down the pipe.
    assign row_fwd = s3_q.fwd ? ((row3_q & ~s3_q.wmask) | (s3_q.din & s3_q.wmask)) : row3_q;

    sram_lane_shifter #(.DATA_W(DATA_W), .SUB_W(SUB_W), .EXP_W(EXP_W)) u_rd_shift (
        .c_i    (s3_q.c),
        .o_i    (s3_q.o),
        .data_i (row_fwd),
        .repl_o (rd_repl_unused),
        .mask_o (rd_mask_unused),
        .ext_o  (rd_lane)
    );

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        s1_d       = '0;
        s1_d.valid = rd_req;
        s1_d.fwd   = collide_req;
        s1_d.oreg  = out_reg;
        s1_d.c     = c_req;
        s1_d.o     = o_r_req;
        s1_d.din   = wr_req ? wr_repl : '0;
        s1_d.wmask = wr_req ? wr_mask : '0;
        cnt_d      = cnt_q;
        if (collide_req && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        lane4_d = (s3_q.valid && s3_q.oreg) ? rd_lane : lane4_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            csb1_q   <= 1'b1;
            base_w_q <= '0;
            base_r_q <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            row3_q   <= '0;
            v4_q     <= 1'b0;
            lane4_q  <= '0;
            cnt_q    <= '0;
        end else begin
            csb0_q   <= csb | web;
            web0_q   <= web;
            csb1_q   <= csb | reb;
            base_w_q <= addr_w[ADDR_W-1:SUB_W];
            base_r_q <= addr_r[ADDR_W-1:SUB_W];
            s1_q     <= s1_d;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            row3_q   <= d_sram_out;
            v4_q     <= s3_q.valid & s3_q.oreg;
            lane4_q  <= lane4_d;
            cnt_q    <= cnt_d;
        end
    end

    // An unregistered result in stage 3 wins over an older registered one.
    assign direct = s3_q.valid & ~s3_q.oreg;

    assign d_sram_in       = s1_q.din;
    assign w_mask          = s1_q.wmask;
    assign csb0_sync       = csb0_q;
    assign web0_sync       = web0_q;
    assign csb1_sync       = csb1_q;
    assign baseaddr_w_sync = base_w_q;
    assign baseaddr_r_sync = base_r_q;
    assign d_fabric_out    = direct ? rd_lane : lane4_q;
    assign rd_valid        = direct | v4_q;
    assign collision_cnt   = cnt_q;

endmodule

// File: tb/tb_sram_ifc_param.sv
// Self-checking bench for sram_ifc_param with a behavioural 1W/1R SRAM model
// and a read scoreboard that checks data and latency of every rd_valid.
module tb_sram_ifc_param;
    import sram_ifc_pkg::*;

    localparam int DATA_W = 32;
    localparam int BASE_W = 9;
    localparam int SUB_W  = 5;
    localparam int ADDR_W = 14;
    localparam int CONF_W = 3;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] d_fabric_in;
    logic              csb, web, reb;
    logic [ADDR_W-1:0] addr_w, addr_r;
    logic [CONF_W-1:0] conf;
    logic              out_reg;
    logic [DATA_W-1:0] d_sram_in, w_mask, d_sram_out, d_fabric_out;
    logic              csb0_sync, web0_sync, csb1_sync, rd_valid;
    logic [BASE_W-1:0] baseaddr_w_sync, baseaddr_r_sync;
    logic [CNT_W-1:0]  collision_cnt;

    sram_ifc_param #(
        .DATA_W(DATA_W), .BASE_W(BASE_W), .CONF_W(CONF_W), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .d_fabric_in     (d_fabric_in),
        .csb             (csb),
        .web             (web),
        .reb             (reb),
        .addr_w          (addr_w),
        .addr_r          (addr_r),
        .conf            (conf),
        .out_reg         (out_reg),
        .d_sram_in       (d_sram_in),
        .w_mask          (w_mask),
        .csb0_sync       (csb0_sync),
        .web0_sync       (web0_sync),
        .csb1_sync       (csb1_sync),
        .baseaddr_w_sync (baseaddr_w_sync),
        .baseaddr_r_sync (baseaddr_r_sync),
        .d_sram_out      (d_sram_out),
        .d_fabric_out    (d_fabric_out),
        .rd_valid        (rd_valid),
        .collision_cnt   (collision_cnt)
    );

    always #5 clk = ~clk;

    // SRAM model: on a same-row collision the written bits read back as garbage.
    logic [31:0] mem [512] = '{default: 32'h0};
    logic [31:0] sram_q = 32'h0;
    always @(posedge clk) begin
        if (!csb0_sync && !web0_sync)
            mem[baseaddr_w_sync] <= (mem[baseaddr_w_sync] & ~w_mask) | (d_sram_in & w_mask);
        if (!csb1_sync) begin
            if (!csb0_sync && !web0_sync && baseaddr_w_sync == baseaddr_r_sync)
                sram_q <= (mem[baseaddr_r_sync] & ~w_mask) | (32'hDEADBEEF & w_mask);
            else
                sram_q <= mem[baseaddr_r_sync];
        end
    end
    assign d_sram_out = sram_q;

    typedef struct {
        logic [31:0] data;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 1 && rd_valid) begin
            if (sb.size() == 0) begin
                check("rd_unexpected", 64'(rd_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rd_data", 64'(d_fabric_out), 64'(mon_e.data));
                check("rd_latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csb = 1'b1;
        web = 1'b1;
        reb = 1'b1;
    endtask

    task automatic req(input logic w, input logic r, input int wrow, input int woff,
                       input int rrow, input int roff, input int cf, input logic oreg,
                       input logic [31:0] wd);
        csb         = !(w || r);
        web         = !w;
        reb         = !r;
        addr_w      = {BASE_W'(wrow), SUB_W'(woff)};
        addr_r      = {BASE_W'(rrow), SUB_W'(roff)};
        conf        = CONF_W'(cf);
        out_reg     = oreg;
        d_fabric_in = wd;
    endtask

    task automatic push(input logic [31:0] d, input logic oreg);
        exp_t e;
        e.data  = d;
        e.issue = cyc;
        e.lat   = oreg ? 4 : 3;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({csb0_sync, web0_sync, csb1_sync, rd_valid}), 64'b1110);
        check({tag, "_mask_din"}, {w_mask, d_sram_in}, 64'h0);
        check({tag, "_base"}, 64'({baseaddr_w_sync, baseaddr_r_sync}), 64'h0);
        check({tag, "_dout"}, 64'(d_fabric_out), 64'h0);
        check({tag, "_cnt"}, 64'(collision_cnt), 64'h0);
    endtask

    typedef struct {
        logic [2:0]  cf;
        int          off;
        logic [31:0] wd;
        logic [31:0] mask;
        logic [31:0] din;
    } wvec_t;

    typedef struct {
        logic [2:0]  cf;
        int          off;
        logic        oreg;
        logic [31:0] lane;
    } rvec_t;

    wvec_t wtab [7];
    rvec_t rtab [9];

    initial begin
        wtab[0] = '{W8,  16, 32'h000000A5, 32'h00FF0000, 32'hA5A5A5A5};
        wtab[1] = '{3'd7, 0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678};
        wtab[2] = '{W1,   7, 32'h00000001, 32'h00000080, 32'hFFFFFFFF};
        wtab[3] = '{W4,   4, 32'h0000000F, 32'h000000F0, 32'hFFFFFFFF};
        wtab[4] = '{W16, 19, 32'h1234BEEF, 32'hFFFF0000, 32'hBEEFBEEF};
        wtab[5] = '{W2,  31, 32'h00000002, 32'hC0000000, 32'hAAAAAAAA};
        wtab[6] = '{W32,  9, 32'hCAFEF00D, 32'hFFFFFFFF, 32'hCAFEF00D};

        rtab[0] = '{W4,   8, 1'b0, 32'h00000006};
        rtab[1] = '{W8,  24, 1'b0, 32'h00000012};
        rtab[2] = '{W16, 16, 1'b0, 32'h00001234};
        rtab[3] = '{W1,   3, 1'b0, 32'h00000001};
        rtab[4] = '{W2,   6, 1'b0, 32'h00000001};
        rtab[5] = '{W32,  0, 1'b0, 32'h12345678};
        rtab[6] = '{W64,  4, 1'b0, 32'h12345678};
        rtab[7] = '{W8,  13, 1'b0, 32'h00000056};
        rtab[8] = '{W4,   8, 1'b1, 32'h00000006};

        rst = 1'b1;
        idle();
        req(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        idle();
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Write path: registered SRAM controls one cycle after each request.
        for (int i = 0; i < 7; i++) begin
            req(1, 0, 20 + i, wtab[i].off, 0, 0, int'(wtab[i].cf), 0, wtab[i].wd);
            step();
            check($sformatf("wr%0d_mask", i), 64'(w_mask), 64'(wtab[i].mask));
            check($sformatf("wr%0d_din", i), 64'(d_sram_in), 64'(wtab[i].din));
            check($sformatf("wr%0d_ctl", i), 64'({csb0_sync, web0_sync, baseaddr_w_sync}),
                  64'({2'b00, BASE_W'(20 + i)}));
        end
        idle();
        step();

        // Row 5 = 0x12345678, then a burst of lane reads.
        req(1, 0, 5, 0, 0, 0, int'(W32), 0, 32'h12345678);
        step();
        idle();
        step();
        for (int i = 0; i < 9; i++) begin
            req(0, 1, 0, 0, 5, rtab[i].off, int'(rtab[i].cf), rtab[i].oreg, 32'h0);
            push(rtab[i].lane, rtab[i].oreg);
            step();
        end
        idle();
        repeat (6) step();

        // Registered read followed by an unregistered one: only the later appears.
        req(0, 1, 0, 0, 5, 0, int'(W8), 1, 32'h0);
        step();
        req(0, 1, 0, 0, 5, 8, int'(W8), 0, 32'h0);
        push(32'h56, 0);
        step();
        idle();
        repeat (6) step();

        // Same-row collisions: written lane forwarded, other bits from the SRAM.
        req(1, 1, 5, 4, 5, 4, int'(W4), 0, 32'hF);
        push(32'hF, 0);
        step();
        req(1, 1, 5, 4, 5, 0, int'(W4), 0, 32'h3);
        push(32'h8, 0);
        step();
        idle();
        repeat (6) step();
        check("coll_cnt_2", 64'(collision_cnt), 64'd2);

        // Write then read next cycle, and different rows in the same cycle.
        req(1, 0, 5, 0, 0, 0, int'(W8), 0, 32'h11);
        step();
        req(0, 1, 0, 0, 5, 0, int'(W8), 0, 32'h0);
        push(32'h11, 0);
        step();
        req(1, 1, 6, 0, 5, 8, int'(W8), 0, 32'h99);
        push(32'h56, 0);
        step();
        idle();
        repeat (6) step();
        check("coll_cnt_hold", 64'(collision_cnt), 64'd2);

        // 20 back-to-back write+read cycles, latency switching from 3 to 4.
        for (int i = 0; i < 20; i++) begin
            req(1, 1, 100 + i, 0, 99 + i, 0, int'(W32), (i >= 10), 32'h01010101 * 32'(i + 1));
            push((i == 0) ? 32'h0 : 32'h01010101 * 32'(i), (i >= 10));
            step();
        end
        idle();
        repeat (8) step();
        check("burst_drain", 64'(sb.size()), 64'd0);

        // Reset lands on a read sitting in stage 2: it must never report.
        req(0, 1, 0, 0, 5, 0, int'(W8), 0, 32'h0);
        step();
        idle();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_flight");
        step();
        check("rst_flight_v4", 64'(rd_valid), 64'd0);
        step();
        check("rst_flight_v5", 64'(rd_valid), 64'd0);

        // Saturation: 70000 full-row collisions, each forwarded result checked.
        for (int i = 0; i < 70000; i++) begin
            logic [31:0] d;
            d = 32'(i) * 32'h9E3779B1;
            req(1, 1, 7, 0, 7, 0, int'(W32), 0, d);
            push(d, 0);
            step();
            if (i == 9) check("coll_cnt_10", 64'(collision_cnt), 64'd10);
        end
        idle();
        repeat (6) step();
        check("coll_cnt_sat", 64'(collision_cnt), 64'hFFFF);

        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
